// File: rtl/lockstep_ctrl.sv
// Lockstep entry/exit sequencer: halts cores, drains outstanding TCDM traffic, then flips lockstep_mode_o.
// Mode/halt are registered (halt +1, mode +2 on a clean entry); same_address_o is combinational.
module lockstep_ctrl #(
  parameter int NB_CORES = 8,
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 3,
  parameter int TIMEOUT  = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enter_req_i,
  input  logic                       exit_req_i,
  input  logic                       clear_i,
  input  logic [NB_CORES-1:0]        core_req_i,
  input  logic [NB_CORES-1:0]        core_gnt_i,
  input  logic [NB_CORES-1:0]        core_rvalid_i,
  input  logic [NB_CORES*ADDR_W-1:0] core_addr_i,
  output logic [NB_CORES-1:0]        core_halt_o,
  output logic                       lockstep_mode_o,
  output logic                       same_address_o,
  output logic                       busy_o,
  output logic                       error_o,
  output logic [2:0]                 state_o
);

  typedef enum logic [2:0] {
    NORMAL    = 3'd0,
    DRAIN_IN  = 3'd1,
    LOCKSTEP  = 3'd2,
    DRAIN_OUT = 3'd3,
    ERROR     = 3'd4
  } state_e;

  localparam logic [7:0] TMO_MAX = 8'(TIMEOUT);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q [NB_CORES];
  logic [CNT_W-1:0]    cnt_d [NB_CORES];
  logic                ovf_q, ovf_d, ovf_now;
  logic [7:0]          tmo_q, tmo_d;
  logic [NB_CORES-1:0] halt_q;
  logic                mode_q;
  logic                clr;
  logic                all_zero, drained, timed_out, addr_eq;

  // Simultaneous issue and response on a core cancel out and never flag overflow.
  always_comb begin
    ovf_now  = 1'b0;
    all_zero = 1'b1;
    for (int k = 0; k < NB_CORES; k++) begin
      cnt_d[k] = cnt_q[k];
      if (cnt_q[k] != '0) all_zero = 1'b0;
      if (core_req_i[k] && core_gnt_i[k] && !core_rvalid_i[k]) begin
        if (&cnt_q[k]) ovf_now = 1'b1;
        else           cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end else if (core_rvalid_i[k] && !(core_req_i[k] && core_gnt_i[k])) begin
        if (cnt_q[k] == '0) ovf_now = 1'b1;
        else                cnt_d[k] = cnt_q[k] - CNT_W'(1);
      end
    end
    drained   = all_zero && (core_req_i == '0);
    timed_out = (tmo_q == TMO_MAX);
  end

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q | ovf_now;
    clr     = 1'b0;
    unique case (state_q)
      NORMAL:    if (enter_req_i) state_d = DRAIN_IN;
      DRAIN_IN: begin
        if (drained)        state_d = LOCKSTEP;
        else if (timed_out) state_d = ERROR;
      end
      LOCKSTEP:  if (exit_req_i) state_d = DRAIN_OUT;
      DRAIN_OUT: begin
        if (drained)        state_d = NORMAL;
        else if (timed_out) state_d = ERROR;
      end
      ERROR: begin
        if (clear_i) begin
          state_d = NORMAL;
          clr     = 1'b1;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ERROR;
    endcase
    if (state_q != ERROR && ovf_d) state_d = ERROR;
  end

  always_comb begin
    tmo_d = 8'd0;
    if (state_d == state_q && (state_q == DRAIN_IN || state_q == DRAIN_OUT))
      tmo_d = timed_out ? tmo_q : tmo_q + 8'd1;
  end

  // Outputs are registered from the next state so they line up with the first cycle in it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= NORMAL;
      ovf_q   <= 1'b0;
      tmo_q   <= 8'd0;
      halt_q  <= '0;
      mode_q  <= 1'b0;
      for (int k = 0; k < NB_CORES; k++) cnt_q[k] <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      halt_q  <= (state_d == DRAIN_IN || state_d == DRAIN_OUT || state_d == ERROR) ?
                 {NB_CORES{1'b1}} : '0;
      mode_q  <= (state_d == LOCKSTEP || state_d == DRAIN_OUT);
      for (int k = 0; k < NB_CORES; k++) cnt_q[k] <= clr ? '0 : cnt_d[k];
    end
  end

  always_comb begin
    addr_eq = 1'b1;
    for (int k = 1; k < NB_CORES; k++)
      if (core_addr_i[k*ADDR_W +: ADDR_W] != core_addr_i[0 +: ADDR_W]) addr_eq = 1'b0;
  end

  assign same_address_o  = mode_q && (&core_req_i) && addr_eq;
  assign core_halt_o     = halt_q;
  assign lockstep_mode_o = mode_q;
  assign busy_o          = (state_q == DRAIN_IN || state_q == DRAIN_OUT || state_q == ERROR);
  assign error_o         = (state_q == ERROR);
  assign state_o         = state_q;

endmodule

// File: tb/tb_lockstep_ctrl.sv
// Directed scenarios plus randomized traffic, checked every cycle against a cycle-level reference model.
module tb_lockstep_ctrl;

  localparam int N  = 8;
  localparam int AW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           enter, exit_r, clear;
  logic [N-1:0]   req, gnt, rvalid;
  logic [N*AW-1:0] addr;
  logic [N-1:0]   halt;
  logic           mode, same, busy, err;
  logic [2:0]     state;

  int n_vec = 0;
  int n_err = 0;

  // reference model: 0 NORMAL, 1 DRAIN_IN, 2 LOCKSTEP, 3 DRAIN_OUT, 4 ERROR
  int m_state;
  int m_cnt [N];
  int m_tmo;
  bit m_ovf;

  lockstep_ctrl #(.NB_CORES(N), .ADDR_W(AW), .CNT_W(3), .TIMEOUT(255)) dut (
    .clk_i(clk), .rst_i(rst), .enter_req_i(enter), .exit_req_i(exit_r), .clear_i(clear),
    .core_req_i(req), .core_gnt_i(gnt), .core_rvalid_i(rvalid), .core_addr_i(addr),
    .core_halt_o(halt), .lockstep_mode_o(mode), .same_address_o(same),
    .busy_o(busy), .error_o(err), .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_tmo = 0; m_ovf = 0;
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
  endtask

  task automatic model_step();
    bit drained, ovf_now;
    int nxt, d;
    drained = (req == '0);
    for (int k = 0; k < N; k++) if (m_cnt[k] != 0) drained = 0;
    ovf_now = 0;
    for (int k = 0; k < N; k++) begin
      d = int'(req[k] & gnt[k]) - int'(rvalid[k]);
      if (m_cnt[k] + d < 0 || m_cnt[k] + d > 7) ovf_now = 1;
      else m_cnt[k] += d;
    end
    nxt = m_state;
    case (m_state)
      0: if (enter) nxt = 1;
      1: if (drained) nxt = 2; else if (m_tmo == 255) nxt = 4;
      2: if (exit_r) nxt = 3;
      3: if (drained) nxt = 0; else if (m_tmo == 255) nxt = 4;
      default: if (clear) nxt = 0;
    endcase
    if (m_state != 4 && (ovf_now || m_ovf)) nxt = 4;
    m_ovf = m_ovf || ovf_now;
    if (m_state == 4 && clear) begin
      m_ovf = 0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
    end
    if (nxt == m_state && (nxt == 1 || nxt == 3)) m_tmo = (m_tmo < 255) ? m_tmo + 1 : 255;
    else m_tmo = 0;
    m_state = nxt;
  endtask

  function automatic bit model_same();
    bit s;
    s = (m_state == 2 || m_state == 3) && (req == '1);
    for (int k = 1; k < N; k++) if (addr[k*AW +: AW] != addr[0 +: AW]) s = 0;
    return s;
  endfunction

  task automatic check_all();
    chk("state", {29'd0, state}, m_state);
    chk("halt", {24'd0, halt}, (m_state == 1 || m_state == 3 || m_state == 4) ? 32'hFF : 32'h0);
    chk("mode", {31'd0, mode}, (m_state == 2 || m_state == 3) ? 1 : 0);
    chk("busy", {31'd0, busy}, (m_state == 1 || m_state == 3 || m_state == 4) ? 1 : 0);
    chk("error", {31'd0, err}, (m_state == 4) ? 1 : 0);
    chk("same_address", {31'd0, same}, {31'd0, model_same()});
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    enter = 0; exit_r = 0; clear = 0;
    req = '0; gnt = '0; rvalid = '0;
  endtask

  initial begin
    int dens;
    logic [31:0] base;
    rst = 1'b1;
    idle();
    addr = '0;
    model_reset();
    #1;
    chk("rst_state", {29'd0, state}, 0);
    chk("rst_halt", {24'd0, halt}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset in the middle of a drain with a counter nonzero
    req[1] = 1; gnt[1] = 1; step();
    idle(); enter = 1; step();
    chk("pre_rst_state", {29'd0, state}, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", {29'd0, state}, 0);
    chk("async_rst_halt", {24'd0, halt}, 0);
    chk("async_rst_mode", {31'd0, mode}, 0);
    chk("async_rst_busy", {31'd0, busy}, 0);
    chk("async_rst_error", {31'd0, err}, 0);
    chk("async_rst_same", {31'd0, same}, 0);
    model_reset();
    idle();
    @(negedge clk);
    rst = 1'b0;

    // clean entry: halt at +1, lockstep at +2 (also proves counters were cleared)
    enter = 1; step();
    chk("entry_halt", {24'd0, halt}, 32'hFF);
    chk("entry_state1", {29'd0, state}, 1);
    enter = 0; step();
    chk("entry_mode", {31'd0, mode}, 1);
    chk("entry_halt_off", {24'd0, halt}, 0);
    chk("entry_state2", {29'd0, state}, 2);

    // broadcast qualifier
    req = '1;
    for (int k = 0; k < N; k++) addr[k*AW +: AW] = 32'h1000_0040;
    #1 chk("bcast_same", {31'd0, same}, 1);
    addr[5*AW +: AW] = 32'h1000_0044;
    #1 chk("bcast_addr5", {31'd0, same}, 0);
    addr[5*AW +: AW] = 32'h1000_0040;
    req[7] = 0;
    #1 chk("bcast_req7", {31'd0, same}, 0);
    step();

    // timeout in DRAIN_OUT: core 0 never answers
    idle(); req[0] = 1; gnt[0] = 1; step();
    idle(); exit_r = 1; step();
    chk("dout_state", {29'd0, state}, 3);
    exit_r = 0;
    repeat (255) step();
    chk("tmo_still_drain", {29'd0, state}, 3);
    step();
    chk("tmo_state", {29'd0, state}, 4);
    chk("tmo_error", {31'd0, err}, 1);
    chk("tmo_mode", {31'd0, mode}, 0);
    clear = 1; step();
    chk("clear_state", {29'd0, state}, 0);
    clear = 0;

    // drain wait: core 3 with two granted reads pending
    req[3] = 1; gnt[3] = 1; step(); step();
    idle(); enter = 1; step();
    repeat (3) begin
      step();
      chk("dwait_busy", {31'd0, busy}, 1);
      chk("dwait_state", {29'd0, state}, 1);
    end
    rvalid[3] = 1; step();
    rvalid[3] = 0; step();
    rvalid[3] = 1; step();
    chk("dwait_busy_last", {31'd0, busy}, 1);
    rvalid[3] = 0; enter = 0; step();
    chk("dwait_locked", {29'd0, state}, 2);

    // leave lockstep, then simultaneous enter+exit in NORMAL
    exit_r = 1; step(); exit_r = 0; step();
    chk("exit_normal", {29'd0, state}, 0);
    enter = 1; exit_r = 1; step();
    chk("both_req", {29'd0, state}, 1);
    idle(); step();
    chk("both_locked", {29'd0, state}, 2);

    // issue and response on the same core cancel
    req[2] = 1; gnt[2] = 1; step();
    rvalid[2] = 1; step();
    idle(); exit_r = 1; step();
    exit_r = 0; rvalid[2] = 1; step();
    chk("cancel_draining", {29'd0, state}, 3);
    rvalid[2] = 0; step();
    chk("cancel_done", {29'd0, state}, 0);

    // response with nothing outstanding
    rvalid[4] = 1; step();
    chk("underflow_state", {29'd0, state}, 4);
    chk("underflow_error", {31'd0, err}, 1);
    rvalid[4] = 0; clear = 1; step();
    chk("underflow_clear", {29'd0, state}, 0);
    clear = 0;

    // randomized traffic
    dens = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) dens = $urandom_range(0, 3);
      enter  = ($urandom_range(0, 7) == 0);
      exit_r = ($urandom_range(0, 7) == 0);
      clear  = ($urandom_range(0, 3) == 0);
      base = $urandom;
      for (int k = 0; k < N; k++) begin
        addr[k*AW +: AW] = base;
        req[k]    = (dens != 0) && ($urandom_range(0, 5) < dens);
        gnt[k]    = (m_cnt[k] < 7) && ($urandom_range(0, 1) == 1);
        rvalid[k] = (m_cnt[k] > 0) ? ($urandom_range(0, 2) == 0)
                                   : ($urandom_range(0, 511) == 0);
      end
      if ($urandom_range(0, 7) == 0) req = '1;
      if ($urandom_range(0, 1) == 0) addr[$urandom_range(0, N-1)*AW +: AW] = ~base;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lockstep_ctrl.md
Name: lockstep_ctrl

Overview:
- Sequences entry to and exit from cluster lockstep mode for NB_CORES cores sharing the TCDM lockstep datapath.
- Halts cores and drains every in-flight TCDM transaction before toggling lockstep_mode_o, so no request straddles a mode change.
- In lockstep, generates the per-cycle broadcast qualifier same_address_o that drives the datapath.
- Sits between the cluster control registers and the lockstep datapath, observing core-side req/gnt/rvalid/addr.

Parameters:
NB_CORES, 8, number of cores controlled.
ADDR_W, 32, TCDM address width.
CNT_W, 3, width of each per-core outstanding-transaction counter.
TIMEOUT, 255, maximum drain cycles before the error state; must fit in 8 bits.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  asynchronous reset, active-high.
enter_req_i  in  1  level request to enter lockstep.
exit_req_i  in  1  level request to leave lockstep.
clear_i  in  1  acknowledges the error state.
core_req_i  in  NB_CORES  per-core TCDM req, core side.
core_gnt_i  in  NB_CORES  per-core TCDM gnt, core side.
core_rvalid_i  in  NB_CORES  per-core TCDM rvalid, core side.
core_addr_i  in  NB_CORES*ADDR_W  per-core address; core k occupies bits [k*ADDR_W +: ADDR_W].
core_halt_o  in/out: out  NB_CORES  halt request to each core.
lockstep_mode_o  out  1  registered lockstep enable to the datapath.
same_address_o  out  1  combinational broadcast qualifier.
busy_o  out  1  high in DRAIN_IN, DRAIN_OUT and ERROR.
error_o  out  1  high in ERROR.
state_o  out  3  current FSM state encoding.

Behaviour:
- Reset (asynchronous, rst_i=1) forces:
  - state NORMAL (encoded 0) and all counters 0.
  - core_halt_o=0, lockstep_mode_o=0, busy_o=0, error_o=0.
  - same_address_o=0 while in reset.
- State encodings: NORMAL=0, DRAIN_IN=1, LOCKSTEP=2, DRAIN_OUT=3, ERROR=4.
- Outstanding counter per core, updated every cycle in all states:
  - +1 on req&gnt; -1 on rvalid; unchanged if both in the same cycle.
  - Increment at all-ones, or decrement at 0, sets the overflow flag, which forces ERROR on the next edge.
  - On overflow the counter holds its value.
- drained = all counters 0 and core_req_i all 0 in the current cycle.
- NORMAL:
  - enter_req_i=1 -> DRAIN_IN; exit_req_i ignored.
  - If both requests are high, enter wins.
- DRAIN_IN:
  - core_halt_o all 1 from the first cycle in the state (registered).
  - Timeout counter cleared on entry, +1 per cycle.
  - drained -> LOCKSTEP.
  - Timeout counter == TIMEOUT and not drained -> ERROR.
- LOCKSTEP:
  - lockstep_mode_o=1 and core_halt_o=0, both registered, on the first cycle in the state.
  - Minimum entry latency from an enter_req_i rising edge with nothing outstanding: halt at cycle +1, lockstep_mode_o at cycle +2.
  - exit_req_i=1 -> DRAIN_OUT; enter_req_i ignored.
- DRAIN_OUT:
  - core_halt_o all 1; lockstep_mode_o stays 1 until the drain completes.
  - drained -> NORMAL; lockstep_mode_o=0 and halt=0 on the first NORMAL cycle.
  - Timeout -> ERROR.
- ERROR:
  - core_halt_o all 1, lockstep_mode_o=0, error_o=1.
  - clear_i=1 -> NORMAL, counters and overflow flag cleared.
  - enter_req_i and exit_req_i are ignored in ERROR.
- same_address_o = lockstep_mode_o & (all core_req_i=1) & (every core_addr_i equal to core 0's address).
  - Otherwise 0; pure combinational, no added latency.
- Halt is a request only; cores may present a req in the cycle halt rises. Such a req blocks drained until it is granted and its rvalid returns.
- Timeout counter is 8 bits and saturates at TIMEOUT; it is held at 0 outside the drain states.

Test Plan:
- Reset mid-DRAIN_IN with counters nonzero:
  - Stimulus: assert rst_i for 1 cycle.
  - Response: all outputs 0 and state_o=0 immediately, without waiting for a clock; counters 0 after release.
- Clean entry:
  - Stimulus: enter_req_i=1 in NORMAL with no traffic.
  - Response: halt=0xFF at cycle +1, lockstep_mode_o=1 and halt=0x00 at cycle +2, state_o=2.
- Drain wait:
  - Stimulus: core 3 has 2 granted reads pending; raise enter_req_i.
  - Response: state stays 1 until the 2nd rvalid_3, then 2 on the next edge; busy_o=1 throughout the drain.
- Broadcast qualifier:
  - Stimulus: in LOCKSTEP, all 8 req=1 with addr=0x1000_0040.
  - Response: same_address_o=1.
  - Changing core 5's address to 0x1000_0044 gives 0; dropping req_7 gives 0.
- Timeout:
  - Stimulus: in DRAIN_OUT, core 0 never returns rvalid.
  - Response: state_o=4 and error_o=1 after 256 drain cycles, lockstep_mode_o=0.
  - clear_i=1 returns the block to NORMAL.
- Simultaneous events:
  - Stimulus: enter_req_i and exit_req_i both 1 in NORMAL.
  - Response: state goes to DRAIN_IN.
  - Stimulus: req&gnt and rvalid on the same core in one cycle.
  - Response: that counter is unchanged.
  - Stimulus: rvalid with counter at 0.
  - Response: ERROR.
